// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/stall/flush controller: drives the per-stage register enables and clears,
// tracks memory-wait, flush and stall events, and flags overlong memory waits.
module pipeline_ctrl #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       id_src1,
  input  logic [3:0]       id_src2,
  input  logic             id_two_src,
  input  logic             id_valid,
  input  logic [3:0]       exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_read,
  input  logic [3:0]       mem_dest,
  input  logic             mem_wb_en,
  input  logic             fwd_en,
  input  logic             exe_branch_taken,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_clr,
  output logic             id_exe_en,
  output logic             id_exe_clr,
  output logic             exe_mem_en,
  output logic             mem_wb_en_o,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] freeze_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout
);

  localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              hazard, freeze, flush, stall;
  logic              match_exe, match_mem;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;

  // Source-register comparison against EXE and MEM destinations.
  always_comb begin
    match_exe = exe_wb_en && ((id_src1 == exe_dest) || (id_two_src && id_src2 == exe_dest));
    match_mem = mem_wb_en && ((id_src1 == mem_dest) || (id_two_src && id_src2 == mem_dest));
    if (fwd_en)
      hazard = id_valid && (state_q != FLUSH) && match_exe && exe_mem_read;
    else
      hazard = id_valid && (state_q != FLUSH) && (match_exe || match_mem);
  end

  assign freeze = !mem_ready;
  assign flush  = mem_ready && exe_branch_taken;
  assign stall  = mem_ready && !exe_branch_taken && hazard;

  // FSM: state register.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // FSM: next state, independent of the current state.
  always_comb begin
    if (!mem_ready)            state_d = MEM_WAIT;
    else if (exe_branch_taken) state_d = FLUSH;
    else                       state_d = RUN;
  end

  // FSM: control outputs, priority freeze > flush > stall > run.
  // NOTE: every output gets a default first so no path leaves one unassigned and infers a latch.
  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    if_id_clr   = 1'b0;
    id_exe_en   = 1'b1;
    id_exe_clr  = 1'b0;
    exe_mem_en  = 1'b1;
    mem_wb_en_o = 1'b1;
    if (freeze) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_exe_en   = 1'b0;
      exe_mem_en  = 1'b0;
      mem_wb_en_o = 1'b0;
    end else if (flush) begin
      if_id_clr  = 1'b1;
      id_exe_clr = 1'b1;
    end else if (stall) begin
      pc_en      = 1'b0;
      if_id_en   = 1'b0;
      id_exe_clr = 1'b1;
    end
  end

  assign state = state_q;

  // Consecutive memory-wait cycles, saturating at TIMEOUT.
  always_comb begin
    wait_nxt = wait_cnt;
    if (mem_ready)              wait_nxt = '0;
    else if (wait_cnt != WAIT_MAX) wait_nxt = wait_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      wait_cnt <= wait_nxt;
      if (freeze && wait_nxt == WAIT_MAX) mem_timeout <= 1'b1;
    end
  end

  // Saturating event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt  <= '0;
      freeze_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (stall  && stall_cnt  != '1) stall_cnt  <= stall_cnt  + 1'b1;
      if (freeze && freeze_cnt != '1) freeze_cnt <= freeze_cnt + 1'b1;
      if (flush  && flush_cnt  != '1) flush_cnt  <= flush_cnt  + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl; small counters and TIMEOUT
// make saturation and timeout reachable in a few cycles.
module tb_pipeline_ctrl;

  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 4;

  // {pc_en, if_id_en, if_id_clr, id_exe_en, id_exe_clr, exe_mem_en, mem_wb_en_o}
  localparam logic [6:0] C_RUN    = 7'b1101011;
  localparam logic [6:0] C_FREEZE = 7'b0000000;
  localparam logic [6:0] C_FLUSH  = 7'b1111111;
  localparam logic [6:0] C_STALL  = 7'b0001111;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] id_src1, id_src2, exe_dest, mem_dest;
  logic id_two_src, id_valid, exe_wb_en, exe_mem_read, mem_wb_en;
  logic fwd_en, exe_branch_taken, mem_ready;
  logic pc_en, if_id_en, if_id_clr, id_exe_en, id_exe_clr, exe_mem_en, mem_wb_en_o;
  logic [1:0] state;
  logic [CNT_W-1:0] stall_cnt, freeze_cnt, flush_cnt;
  logic mem_timeout;
  logic [6:0] ctrl;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src), .id_valid(id_valid),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .fwd_en(fwd_en),
    .exe_branch_taken(exe_branch_taken), .mem_ready(mem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_clr(if_id_clr),
    .id_exe_en(id_exe_en), .id_exe_clr(id_exe_clr),
    .exe_mem_en(exe_mem_en), .mem_wb_en_o(mem_wb_en_o),
    .state(state), .stall_cnt(stall_cnt), .freeze_cnt(freeze_cnt), .flush_cnt(flush_cnt),
    .mem_timeout(mem_timeout)
  );

  assign ctrl = {pc_en, if_id_en, if_id_clr, id_exe_en, id_exe_clr, exe_mem_en, mem_wb_en_o};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    id_src1 = 4'd0; id_src2 = 4'd0; id_two_src = 1'b0; id_valid = 1'b0;
    exe_dest = 4'd0; exe_wb_en = 1'b0; exe_mem_read = 1'b0;
    mem_dest = 4'd0; mem_wb_en = 1'b0; fwd_en = 1'b0;
    exe_branch_taken = 1'b0; mem_ready = 1'b1;
  endtask

  initial begin
    set_idle();
    #1 rst = 1'b1;
    #1;
    check("rst_state", state, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_freeze_cnt", freeze_cnt, 0);
    check("rst_flush_cnt", flush_cnt, 0);
    check("rst_timeout", mem_timeout, 0);
    check("rst_ctrl_run", ctrl, C_RUN);
    step();
    step();
    rst = 1'b0;

    // Load-use style hazard on EXE without forwarding.
    id_valid = 1'b1; id_src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1'b1;
    #1 check("exe_hazard_stall", ctrl, C_STALL);
    step();
    check("stall_cnt_1", stall_cnt, 1);
    check("state_run_after_stall", state, 0);

    // MEM destination matched through the second source.
    exe_wb_en = 1'b0; id_src1 = 4'd1; id_src2 = 4'd7; id_two_src = 1'b1;
    mem_dest = 4'd7; mem_wb_en = 1'b1;
    #1 check("mem_hazard_src2", ctrl, C_STALL);
    step();
    check("stall_cnt_2", stall_cnt, 2);
    id_two_src = 1'b0;
    #1 check("src2_unused_no_stall", ctrl, C_RUN);
    id_two_src = 1'b1; id_valid = 1'b0;
    #1 check("bubble_no_stall", ctrl, C_RUN);

    // Forwarding: only a load in EXE stalls.
    id_valid = 1'b1; id_two_src = 1'b0; id_src1 = 4'd3; fwd_en = 1'b1;
    exe_dest = 4'd3; exe_wb_en = 1'b1; mem_dest = 4'd3; mem_wb_en = 1'b1;
    #1 check("fwd_no_stall", ctrl, C_RUN);
    step();
    check("fwd_stall_cnt_hold", stall_cnt, 2);
    exe_mem_read = 1'b1;
    #1 check("fwd_load_stall", ctrl, C_STALL);
    step();
    check("stall_cnt_3", stall_cnt, 3);

    // Branch beats hazard; FLUSH state masks the hazard for one cycle.
    exe_branch_taken = 1'b1;
    #1 check("branch_over_hazard", ctrl, C_FLUSH);
    step();
    check("state_flush", state, 2);
    check("flush_cnt_1", flush_cnt, 1);
    exe_branch_taken = 1'b0;
    #1 check("flush_masks_hazard", ctrl, C_RUN);
    step();
    check("stall_cnt_hold_flush", stall_cnt, 3);
    check("state_back_run", state, 0);
    #1 check("hazard_again_in_run", ctrl, C_STALL);

    // Freeze beats a pending branch for three cycles, then the flush happens.
    set_idle();
    mem_ready = 1'b0; exe_branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check("freeze_ctrl", ctrl, C_FREEZE);
      step();
      check("state_mem_wait", state, 1);
    end
    check("freeze_cnt_3", freeze_cnt, 3);
    check("flush_cnt_hold_freeze", flush_cnt, 1);
    check("no_timeout_at_3", mem_timeout, 0);
    mem_ready = 1'b1;
    #1 check("flush_after_wait", ctrl, C_FLUSH);
    step();
    check("state_flush_after_wait", state, 2);
    check("flush_cnt_2", flush_cnt, 2);
    exe_branch_taken = 1'b0;
    step();
    check("state_run_after_flush", state, 0);

    // Timeout after TIMEOUT consecutive wait cycles, sticky afterwards.
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("timeout_not_yet", mem_timeout, 0);
    step();
    check("timeout_set", mem_timeout, 1);
    check("freeze_cnt_7", freeze_cnt, 7);
    mem_ready = 1'b1;
    step();
    check("timeout_sticky", mem_timeout, 1);
    check("state_run_after_timeout", state, 0);

    // Counter saturation: 7 + 12 freeze cycles clamps at 15.
    mem_ready = 1'b0;
    for (int i = 0; i < 12; i++) step();
    check("freeze_cnt_sat", freeze_cnt, 15);

    // Asynchronous reset in the middle of a wait.
    #2 rst = 1'b1;
    #1;
    check("arst_state", state, 0);
    check("arst_freeze_cnt", freeze_cnt, 0);
    check("arst_stall_cnt", stall_cnt, 0);
    check("arst_flush_cnt", flush_cnt, 0);
    check("arst_timeout", mem_timeout, 0);
    check("rst_ctrl_freeze", ctrl, C_FREEZE);
    step();
    rst = 1'b0;

    // Asynchronous reset in the middle of a flush.
    mem_ready = 1'b1; exe_branch_taken = 1'b1;
    step();
    check("state_flush_pre_rst", state, 2);
    exe_branch_taken = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_flush_state", state, 0);
    check("arst_flush_cnt2", flush_cnt, 0);
    step();
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameters: CNT_W, default 16, width of event counters; TIMEOUT, default 255, consecutive memory-wait cycles before mem_timeout is set.
REQ-002 SHALL have ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
REQ-003 SHALL have ID-side inputs:
- id_src1  in  4  first source register of the instruction in ID
- id_src2  in  4  second source register of the instruction in ID
- id_two_src  in  1  instruction in ID reads id_src2
- id_valid  in  1  ID holds a real instruction, not a bubble
REQ-004 SHALL have EXE/MEM-side inputs:
- exe_dest  in  4  destination register in EXE
- exe_wb_en  in  1  EXE instruction writes back
- exe_mem_read  in  1  EXE instruction is a load
- mem_dest  in  4  destination register in MEM
- mem_wb_en  in  1  MEM instruction writes back
- fwd_en  in  1  forwarding unit active
- exe_branch_taken  in  1  branch resolved taken in EXE
- mem_ready  in  1  memory subsystem can complete this cycle
REQ-005 SHALL have control outputs, all 1 bit:
- pc_en  out  PC register enable
- if_id_en, if_id_clr  out  IF/ID register enable and clear
- id_exe_en, id_exe_clr  out  ID/EXE register enable and clear
- exe_mem_en, mem_wb_en_o  out  EXE/MEM and MEM/WB register enables
REQ-006 SHALL have status outputs:
- state  out  2  0=RUN, 1=MEM_WAIT, 2=FLUSH
- stall_cnt, freeze_cnt, flush_cnt  out  CNT_W each  event counters
- mem_timeout  out  1  sticky timeout flag

Function
REQ-007 SHALL drive control outputs combinationally from the current state and inputs. Every clr SHALL take priority over its en in the downstream register.
REQ-008 hazard SHALL be asserted when all of the following hold: id_valid=1; state!=FLUSH; and a source matches.
- Source match: (id_src1==D) or (id_two_src and id_src2==D).
- fwd_en=0: D=exe_dest with exe_wb_en=1, or D=mem_dest with mem_wb_en=1.
- fwd_en=1: only D=exe_dest with exe_wb_en=1 and exe_mem_read=1.
REQ-009 Priority 1, freeze (mem_ready=0): pc_en, all en = 0; all clr = 0; branch and hazard are ignored.
REQ-010 Priority 2, flush (mem_ready=1, exe_branch_taken=1): pc_en=1, all en=1, if_id_clr=1, id_exe_clr=1; hazard is ignored.
REQ-011 Priority 3, stall (mem_ready=1, no branch, hazard=1): pc_en=0, if_id_en=0, id_exe_en=1, id_exe_clr=1, exe_mem_en=1, mem_wb_en_o=1.
REQ-012 Otherwise: pc_en=1, all en=1, all clr=0.
REQ-013 FSM next state, evaluated identically from every state:
- mem_ready=0 -> MEM_WAIT
- else exe_branch_taken=1 -> FLUSH
- else -> RUN
REQ-014 FLUSH SHALL last exactly one cycle unless a new flush or freeze condition applies.
REQ-015 Counters SHALL saturate at 2^CNT_W-1 and never wrap:
- stall_cnt increments on each stall cycle.
- freeze_cnt increments on each freeze cycle.
- flush_cnt increments on each flush cycle.
REQ-016 Internal wait_cnt SHALL:
- increment on each freeze cycle;
- clear on any cycle with mem_ready=1;
- saturate at TIMEOUT.
REQ-017 mem_timeout SHALL set on the edge where wait_cnt reaches TIMEOUT and stay set until rst.

Reset
REQ-018 rst=1 SHALL immediately force state=RUN, all counters=0, wait_cnt=0 and mem_timeout=0, including mid-wait or mid-flush.
REQ-019 During rst, control outputs SHALL follow REQ-009..REQ-012 from state RUN.

Verification
REQ-020 fwd_en=0, id_src1=3, exe_dest=3, exe_wb_en=1, id_valid=1, mem_ready=1 -> pc_en=0, if_id_en=0, id_exe_clr=1; stall_cnt=1 after the edge.
REQ-021 fwd_en=1, same match, exe_mem_read=0 -> no stall, all en=1. Set exe_mem_read=1 -> stall for exactly that cycle.
REQ-022 exe_branch_taken=1 together with hazard -> if_id_clr=1, id_exe_clr=1, pc_en=1. Next cycle state=2, and the hazard inputs produce no stall.
REQ-023 mem_ready=0 for 3 cycles with exe_branch_taken=1 -> all en=0 and no clr during the wait, freeze_cnt=3. On mem_ready=1 -> flush asserted, state=2 next cycle.
REQ-024 TIMEOUT=4, mem_ready=0 for 4 cycles -> mem_timeout=1 after the 4th edge and remains 1 after mem_ready=1. rst=1 -> state=0, counters=0, mem_timeout=0 without waiting for a clock.
